sdram_host_arbiter: RTL and testbench

Single-clock, parametrised N-channel host arbiter in front of `sdram_controller`: multiplexes up to `NUM_CH` independent read/write clients onto the controller's single host port and routes each read word back to the channel that issued it. Sits in the 100 MHz domain between the per-client cross-clock FIFOs and the controller, replacing the fixed one-client wiring. Supports round-robin or fixed-priority arbitration.

---
 rtl/sdram_host_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_host_arbiter
//  Purpose  : N-channel host arbiter in front of sdram_controller. Picks one
//             requesting client (round-robin or fixed priority), issues its
//             read/write on the controller's single host port, acknowledges
//             it, and routes each returned read word to the issuing channel.
//  Ports    : clk, rst_n                  clock, async active-low reset
//             ch_wr_enable/ch_rd_enable   per-channel level requests
//             ch_addr/ch_wr_data          packed per-channel address / data
//             ch_ack                      one-hot acceptance pulse
//             ch_rd_data/ch_rd_ready      shared read data + one-hot valid
//             wr_addr/rd_addr/wr_data     controller host port
//             wr_enable/rd_enable         controller host port strobes
//             busy/rd_data/rd_ready       controller status / read return
//  Revision : 1.0  initial release
// ============================================================================
module sdram_host_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             ch_wr_enable,
  input  logic [NUM_CH-1:0]             ch_rd_enable,
  input  logic [NUM_CH*HADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_wr_data,
  output logic [NUM_CH-1:0]             ch_ack,
  output logic [DATA_WIDTH-1:0]         ch_rd_data,
  output logic [NUM_CH-1:0]             ch_rd_ready,
  output logic [HADDR_WIDTH-1:0]        wr_addr,
  output logic [HADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_enable,
  output logic                          rd_enable,
  input  logic                          busy,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_ready
);

  localparam int                IDX_W      = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0]  C_LAST_RST = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] C_ONE      = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_last;
  logic               r_op_wr;
  logic               r_rd_done;

  logic [NUM_CH-1:0]      w_req;
  logic [NUM_CH-1:0]      w_gnt_oh;
  logic [IDX_W-1:0]       w_lo_idx;
  logic [IDX_W-1:0]       w_hi_idx;
  logic                   w_hi_found;
  logic [IDX_W-1:0]       w_sel;
  logic [HADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_sel_wr;

  // A channel being acknowledged this cycle is masked so its stale request
  // can never be granted a second time.
  assign w_req    = (ch_wr_enable | ch_rd_enable) & ~ch_ack;
  assign w_gnt_oh = C_ONE << r_gnt;

  // Round-robin as two lowest-index searches: first among channels above
  // the last winner, otherwise wrap around to the lowest requester overall.
  always_comb begin
    w_lo_idx   = '0;
    w_hi_idx   = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_lo_idx = IDX_W'(i);
        if (IDX_W'(i) > r_last) begin
          w_hi_idx   = IDX_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  assign w_sel = ((FIXED_PRIO == 0) && w_hi_found) ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_wr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_sel_addr = ch_addr[i*HADDR_WIDTH +: HADDR_WIDTH];
        w_sel_data = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        // write wins when a channel raises both enables
        w_sel_wr   = ch_wr_enable[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_last      <= C_LAST_RST;
      r_op_wr     <= 1'b0;
      r_rd_done   <= 1'b0;
      ch_ack      <= '0;
      ch_rd_data  <= '0;
      ch_rd_ready <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_data     <= '0;
      wr_enable   <= 1'b0;
      rd_enable   <= 1'b0;
    end else begin
      ch_ack      <= '0;
      ch_rd_ready <= '0;

      // Read words are only meaningful while a transaction is in flight.
      if (rd_ready && (r_state == S_ISSUE || r_state == S_WAIT)) begin
        ch_rd_data  <= rd_data;
        ch_rd_ready <= w_gnt_oh;
      end

      case (r_state)
        S_IDLE: begin
          if ((|w_req) && !busy) begin
            r_gnt     <= w_sel;
            r_last    <= w_sel;
            r_op_wr   <= w_sel_wr;
            r_rd_done <= 1'b0;
            if (w_sel_wr) begin
              wr_addr   <= w_sel_addr;
              wr_data   <= w_sel_data;
              wr_enable <= 1'b1;
            end else begin
              rd_addr   <= w_sel_addr;
              rd_enable <= 1'b1;
            end
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (rd_ready) begin
            r_rd_done <= 1'b1;
          end
          // Controller raising busy is the acceptance handshake.
          if (busy) begin
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            ch_ack    <= w_gnt_oh;
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rd_ready) begin
            r_rd_done <= 1'b1;
          end
          if (!busy && (r_op_wr || r_rd_done)) begin
            r_rd_done <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_host_arbiter
//  Purpose  : Self-checking bench for sdram_host_arbiter. Two instances
//             (round-robin and fixed-priority) share client/controller
//             stimulus; one is observed at a time. Clients and a reactive
//             controller model are driven on the falling edge; a
//             transaction-level arbitration model predicts every grant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_host_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NCH-1:0]      ch_wr_enable, ch_rd_enable;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*DW-1:0]   ch_wr_data;
  logic                busy, rd_ready;
  logic [DW-1:0]       rd_data;

  logic [NCH-1:0] rr_ack, rr_rrdy, fp_ack, fp_rrdy;
  logic [DW-1:0]  rr_rdata, fp_rdata, rr_wdata, fp_wdata;
  logic [AW-1:0]  rr_waddr, rr_raddr, fp_waddr, fp_raddr;
  logic           rr_wen, rr_ren, fp_wen, fp_ren;

  sdram_host_arbiter #(.NUM_CH(NCH), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_wr_enable(ch_wr_enable), .ch_rd_enable(ch_rd_enable),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_ack(rr_ack), .ch_rd_data(rr_rdata),
    .ch_rd_ready(rr_rrdy), .wr_addr(rr_waddr), .rd_addr(rr_raddr), .wr_data(rr_wdata),
    .wr_enable(rr_wen), .rd_enable(rr_ren), .busy(busy), .rd_data(rd_data), .rd_ready(rd_ready));

  sdram_host_arbiter #(.NUM_CH(NCH), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_wr_enable(ch_wr_enable), .ch_rd_enable(ch_rd_enable),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_ack(fp_ack), .ch_rd_data(fp_rdata),
    .ch_rd_ready(fp_rrdy), .wr_addr(fp_waddr), .rd_addr(fp_raddr), .wr_data(fp_wdata),
    .wr_enable(fp_wen), .rd_enable(fp_ren), .busy(busy), .rd_data(rd_data), .rd_ready(rd_ready));

  // Observed instance
  logic           use_fp;
  logic [NCH-1:0] obs_ack, obs_rrdy;
  logic [DW-1:0]  obs_rdata, obs_wdata;
  logic [AW-1:0]  obs_waddr, obs_raddr;
  logic           obs_wen, obs_ren;
  assign obs_ack   = use_fp ? fp_ack   : rr_ack;
  assign obs_rrdy  = use_fp ? fp_rrdy  : rr_rrdy;
  assign obs_rdata = use_fp ? fp_rdata : rr_rdata;
  assign obs_wdata = use_fp ? fp_wdata : rr_wdata;
  assign obs_waddr = use_fp ? fp_waddr : rr_waddr;
  assign obs_raddr = use_fp ? fp_raddr : rr_raddr;
  assign obs_wen   = use_fp ? fp_wen   : rr_wen;
  assign obs_ren   = use_fp ? fp_ren   : rr_ren;

  int n_checks = 0;
  int n_fail   = 0;

  // Client state
  logic [NCH-1:0] c_wr, c_rd, c_auto;
  logic [AW-1:0]  c_addr [NCH];
  logic [DW-1:0]  c_data [NCH];
  bit             wr_only, rand_start;
  int             acks_seen [NCH];

  // Controller model state
  int      ctl_cnt;
  bit      ctl_is_rd, ctl_sent, ctl_hold;
  logic [DW-1:0] rd_force [$];

  // Reference model state
  int      model_last, model_gnt, stall, tot_grants, tot_acks;
  bit      prev_en, rd_pulse_prev;
  logic [DW-1:0] rd_val_prev;
  int      grant_log [$];
  bit      op_log [$];
  logic [NCH-1:0] rdy_log [$];
  logic [DW-1:0]  rdat_log [$];

  localparam int RR_EXP [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] onehot(input int g);
    logic [NCH-1:0] v;
    v = '0;
    if (g >= 0 && g < NCH) v[g] = 1'b1;
    return v;
  endfunction

  // Next grant straight from the arbitration rules.
  function automatic int ref_pick(input logic [NCH-1:0] req, input int last, input bit fixed);
    if (fixed) begin
      for (int c = 0; c < NCH; c++) if (req[c]) return c;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (last + k) % NCH;
        if (req[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic apply_clients();
    ch_wr_enable = c_wr;
    ch_rd_enable = c_rd;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW]    = c_addr[i];
      ch_wr_data[i*DW +: DW] = c_data[i];
    end
  endtask

  task automatic new_req(input int i);
    int r;
    r = wr_only ? 0 : int'($urandom_range(0, 3));
    c_wr[i]   = (r != 2);
    c_rd[i]   = (r >= 2);
    c_addr[i] = AW'($urandom);
    c_data[i] = DW'($urandom);
  endtask

  task automatic clear_clients();
    c_wr = '0; c_rd = '0; c_auto = '0;
    for (int i = 0; i < NCH; i++) begin
      c_addr[i] = '0; c_data[i] = '0;
    end
    apply_clients();
  endtask

  // One clock: check at the falling edge, then update clients and controller.
  task automatic cycle();
    logic           cur_en, is_wr;
    logic [NCH-1:0] req_now;
    int             g;
    @(negedge clk);
    cur_en  = obs_wen | obs_ren;
    req_now = ch_wr_enable | ch_rd_enable;

    chk("ack", {28'd0, obs_ack}, {28'd0, (prev_en && busy) ? onehot(model_gnt) : 4'b0});
    if (prev_en && busy) chk("enable_drop", {31'd0, cur_en}, 32'd0);
    chk("rd_route", {28'd0, obs_rrdy}, {28'd0, rd_pulse_prev ? onehot(model_gnt) : 4'b0});
    if (rd_pulse_prev) chk("rd_data", {16'd0, obs_rdata}, {16'd0, rd_val_prev});
    if (obs_rrdy != '0) begin
      rdy_log.push_back(obs_rrdy);
      rdat_log.push_back(obs_rdata);
    end

    if (cur_en && !prev_en) begin
      g = ref_pick(req_now, model_last, use_fp);
      chk("grant_exists", {31'd0, g >= 0}, 32'd1);
      if (g >= 0) begin
        is_wr = ch_wr_enable[g];
        chk("grant_wr_en", {31'd0, obs_wen}, {31'd0, is_wr});
        chk("grant_rd_en", {31'd0, obs_ren}, {31'd0, !is_wr});
        if (is_wr) begin
          chk("wr_addr", {8'd0, obs_waddr}, {8'd0, c_addr[g]});
          chk("wr_data", {16'd0, obs_wdata}, {16'd0, c_data[g]});
        end else begin
          chk("rd_addr", {8'd0, obs_raddr}, {8'd0, c_addr[g]});
        end
        model_gnt  = g;
        model_last = g;
        grant_log.push_back(g);
        op_log.push_back(is_wr);
        tot_grants++;
      end
    end

    if (cur_en) stall = 0;
    else if (|req_now) stall++;
    if (stall > 60) begin
      chk("stall_cycles", stall, 60);
      stall = 0;
    end

    for (int i = 0; i < NCH; i++) begin
      if (obs_ack[i]) begin
        acks_seen[i]++;
        tot_acks++;
        if (c_wr[i] && c_rd[i]) c_wr[i] = 1'b0;
        else if (c_auto[i]) new_req(i);
        else begin
          c_wr[i] = 1'b0;
          c_rd[i] = 1'b0;
        end
      end else if (rand_start && !c_wr[i] && !c_rd[i] && $urandom_range(0, 7) == 0) begin
        new_req(i);
      end
    end

    rd_ready = 1'b0;
    if (!busy) begin
      if (cur_en) begin
        busy      = 1'b1;
        ctl_cnt   = int'($urandom_range(1, 3));
        ctl_is_rd = obs_ren;
        ctl_sent  = 1'b0;
      end
    end else if (!ctl_hold) begin
      if (ctl_is_rd && !ctl_sent && (ctl_cnt == 1 || $urandom_range(0, 1) == 1)) begin
        rd_ready = 1'b1;
        rd_data  = (rd_force.size() > 0) ? rd_force.pop_front() : DW'($urandom);
        ctl_sent = 1'b1;
      end
      ctl_cnt--;
      if (ctl_cnt == 0) busy = 1'b0;
    end
    rd_pulse_prev = rd_ready;
    rd_val_prev   = rd_data;
    prev_en       = cur_en;
    apply_clients();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rr_ctl", {18'd0, rr_ack, rr_rrdy, rr_wen, rr_ren}, 32'd0);
    chk("rst_rr_bus", {31'd0, |{rr_rdata, rr_waddr, rr_raddr, rr_wdata}}, 32'd0);
    chk("rst_fp_ctl", {18'd0, fp_ack, fp_rrdy, fp_wen, fp_ren}, 32'd0);
    chk("rst_fp_bus", {31'd0, |{fp_rdata, fp_waddr, fp_raddr, fp_wdata}}, 32'd0);
  endtask

  // Asserted away from any clock edge so the outputs must clear asynchronously.
  task automatic do_reset(input bit check);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (check) chk_reset_outputs();
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0; ctl_hold = 1'b0; ctl_cnt = 0;
    clear_clients();
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    model_last    = NCH - 1;
    model_gnt     = 0;
    prev_en       = 1'b0;
    rd_pulse_prev = 1'b0;
    stall         = 0;
  endtask

  task automatic drain();
    c_auto = '0;
    rand_start = 1'b0;
    for (int k = 0; k < 300 && ((|(c_wr | c_rd)) || busy); k++) cycle();
    for (int k = 0; k < 3; k++) cycle();
    chk("drained", {31'd0, (|(c_wr | c_rd)) || busy}, 32'd0);
  endtask

  task automatic clear_logs();
    grant_log.delete(); op_log.delete(); rdy_log.delete(); rdat_log.delete();
    for (int i = 0; i < NCH; i++) acks_seen[i] = 0;
  endtask

  initial begin
    rst_n = 1'b1; use_fp = 1'b0; busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    wr_only = 1'b1; rand_start = 1'b0; ctl_hold = 1'b0; ctl_cnt = 0;
    tot_grants = 0; tot_acks = 0;
    clear_clients();
    clear_logs();

    // Reset state
    do_reset(1'b1);

    // Single write on channel 2
    c_wr[2] = 1'b1; c_addr[2] = 24'h000123; c_data[2] = 16'hBEEF;
    apply_clients();
    drain();
    chk("single_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_gnt_ch", grant_log[0], 2);
    chk("single_acks_ch2", acks_seen[2], 1);
    chk("single_acks_other", acks_seen[0] + acks_seen[1] + acks_seen[3], 0);

    // Round-robin fairness
    do_reset(1'b0);
    clear_logs();
    for (int i = 0; i < NCH; i++) new_req(i);
    c_auto = '1;
    apply_clients();
    for (int k = 0; k < 100 && grant_log.size() < 6; k++) cycle();
    chk("rr_grant_count", {31'd0, grant_log.size() >= 6}, 32'd1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("rr_order_%0d", k), grant_log[k], RR_EXP[k]);
    drain();

    // Read routing
    clear_logs();
    wr_only = 1'b0;
    c_rd[1] = 1'b1; c_addr[1] = 24'h0000A0;
    rd_force.push_back(16'h1234);
    apply_clients();
    drain();
    c_rd[3] = 1'b1; c_addr[3] = 24'h0003C4;
    rd_force.push_back(16'h5678);
    apply_clients();
    drain();
    chk("rdrt_events", rdy_log.size(), 2);
    if (rdy_log.size() == 2) begin
      chk("rdrt_ch1_oh", {28'd0, rdy_log[0]}, 32'h2);
      chk("rdrt_ch1_data", {16'd0, rdat_log[0]}, 32'h1234);
      chk("rdrt_ch3_oh", {28'd0, rdy_log[1]}, 32'h8);
      chk("rdrt_ch3_data", {16'd0, rdat_log[1]}, 32'h5678);
    end

    // Dual request: write first, then read
    clear_logs();
    c_wr[0] = 1'b1; c_rd[0] = 1'b1; c_addr[0] = 24'h000010; c_data[0] = 16'hA55A;
    apply_clients();
    drain();
    chk("dual_acks", acks_seen[0], 2);
    chk("dual_grants", op_log.size(), 2);
    if (op_log.size() == 2) begin
      chk("dual_first_wr", {31'd0, op_log[0]}, 32'd1);
      chk("dual_second_rd", {31'd0, op_log[1]}, 32'd0);
    end

    // Fixed priority
    use_fp = 1'b1;
    wr_only = 1'b1;
    do_reset(1'b0);
    clear_logs();
    new_req(1); new_req(3);
    c_auto[1] = 1'b1; c_auto[3] = 1'b1;
    apply_clients();
    for (int k = 0; k < 40; k++) cycle();
    begin
      int n1, n3;
      n1 = 0; n3 = 0;
      foreach (grant_log[j]) begin
        if (grant_log[j] == 1) n1++;
        if (grant_log[j] == 3) n3++;
      end
      chk("fp_ch3_starved", n3, 0);
      chk("fp_ch1_served", {31'd0, n1 >= 3}, 32'd1);
    end
    c_auto[1] = 1'b0;
    for (int k = 0; k < 60 && acks_seen[3] == 0; k++) cycle();
    chk("fp_ch3_after_drop", {31'd0, acks_seen[3] > 0}, 32'd1);
    drain();

    // Reset in the middle of a read
    use_fp = 1'b0;
    wr_only = 1'b0;
    do_reset(1'b0);
    clear_logs();
    c_rd[2] = 1'b1; c_addr[2] = 24'h00BEEF;
    ctl_hold = 1'b1;
    apply_clients();
    for (int k = 0; k < 20 && acks_seen[2] == 0; k++) cycle();
    chk("midrd_acked", acks_seen[2], 1);
    cycle();
    do_reset(1'b1);
    clear_logs();
    rd_ready = 1'b1; rd_data = 16'hDEAD;
    cycle();
    chk("stray_rd_data", {16'd0, obs_rdata}, 32'd0);
    c_wr[0] = 1'b1; c_addr[0] = 24'h000040; c_data[0] = 16'h0F0F;
    c_wr[3] = 1'b1; c_addr[3] = 24'h000300; c_data[3] = 16'hF0F0;
    apply_clients();
    drain();
    chk("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 0);

    // Randomized traffic, round-robin then fixed priority
    for (int m = 0; m < 2; m++) begin
      use_fp = (m == 1);
      do_reset(1'b0);
      clear_logs();
      c_auto = '1;
      rand_start = 1'b1;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 1) == 1) new_req(i);
      apply_clients();
      for (int k = 0; k < (m == 0 ? 1500 : 800); k++) cycle();
      chk("rand_progress", {31'd0, grant_log.size() > 50}, 32'd1);
      drain();
    end
    chk("grant_ack_balance", tot_acks, tot_grants);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
